pwm_timer_multi: RTL and testbench
==================================

PWM_TIMER_MULTI -- requirements
Module: pwm_timer_multi

Interface
REQ-001 SHALL have parameter CH, default 4: number of independent timer channels (1..16).
REQ-002 SHALL have parameter CW, default 16: width of MAX/DUTY/STOP registers and counters.
REQ-003 SHALL have parameter END_LEN, default 10: o_timer_end pulse length in clocks (1..255).
REQ-004 SHALL have port i_clk  input  1  clock; all state on rising edge.
REQ-005 SHALL have port i_rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port i_we  input  1  register write strobe.
REQ-007 SHALL have port i_addr  input  $clog2(CH)+2  {channel, reg[1:0]}; reg 0=MAX, 1=DUTY, 2=STOP, 3=POL.
REQ-008 SHALL have port i_wdata  input  CW  write data.
REQ-009 SHALL have port i_start  input  CH  per-channel start level, sampled in IDLE.
REQ-010 SHALL have port i_abort  input  CH  per-channel abort.
REQ-011 SHALL have port o_pwm  output  CH  registered PWM outputs.
REQ-012 SHALL have port o_timer_end  output  CH  registered end pulses.
REQ-013 SHALL have port o_busy  output  CH  high while channel is in RUN or END.

Function
REQ-014 Each channel SHALL run an independent FSM: IDLE, RUN, END; default branch -> IDLE.
REQ-015 Writes SHALL be accepted only when the addressed channel is in IDLE; writes to RUN/END channels are dropped; channel index >= CH is ignored.
REQ-016 IDLE: i_start[c]=1 -> RUN next edge; inner and cycle counters cleared to 0; a write in that same cycle SHALL be used by the run.
REQ-017 RUN: inner counter SHALL count 0..MAX-1 then wrap to 0, incrementing cycle counter on wrap.
REQ-018 RUN: o_pwm SHALL be registered compare of the inner counter: 0 while cnt<DUTY, 1 while DUTY<=cnt<MAX, one-clock latency.
REQ-019 Period SHALL be exactly MAX clocks, high time MAX-DUTY clocks; DUTY=0 -> constant 1, DUTY>=MAX -> constant 0.
REQ-020 When cycle counter reaches STOP, the channel SHALL enter END; o_pwm=0 from that edge.
REQ-021 MAX=0 or STOP=0 SHALL end the run after one RUN clock with o_pwm never asserted.
REQ-022 END: o_timer_end SHALL be 1 for exactly END_LEN clocks, then 0 and FSM -> IDLE; i_start ignored during END.
REQ-023 i_abort[c] in RUN or END SHALL force IDLE next edge, o_pwm=0, o_timer_end=0; abort has priority over all other events.
REQ-024 Counters SHALL be CW bits, unsigned; no overflow possible since MAX, STOP are CW bits.
REQ-025 Registers (MAX, DUTY, STOP) SHALL hold value across runs until rewritten.

Reset
REQ-026 i_rst_n low SHALL asynchronously set all FSMs to IDLE, all registers and counters to 0, o_pwm=0, o_timer_end=0, o_busy=0.
REQ-027 Reset mid-RUN SHALL abort with no o_timer_end pulse.

Configuration
REQ-028 Macro PWM_TIMER_POLARITY_EN defined: reg 3 bit 0 per channel SHALL invert o_pwm in RUN only (idle/END level stays 0).
REQ-029 Macro undefined: reg 3 writes SHALL be ignored, no polarity flop synthesised.

Structure
REQ-030 Package pwm_timer_pkg SHALL hold the state encoding (IDLE=0, RUN=1, END=2) and register offsets REG_MAX..REG_POL.
REQ-031 Per-channel logic SHALL be sub-module pwm_timer_ch, instantiated CH times by generate; top holds address decode.

Verification
REQ-032 CH=4, ch0 MAX=10 DUTY=4 STOP=3, start -> o_pwm[0] low 4/high 6 clocks, 3 periods, then o_timer_end[0] high 10 clocks, o_busy[0] low after.
REQ-033 ch1 DUTY=0 MAX=5 STOP=2 and ch2 DUTY=8 MAX=5 -> o_pwm[1] constant 1 for 10 clocks; o_pwm[2] constant 0.
REQ-034 Write MAX=20 to ch0 during RUN -> period stays 10; next run uses old value 10.
REQ-035 Abort ch0 at 3rd period -> o_pwm[0]=0 next edge, no o_timer_end pulse, o_busy[0]=0.
REQ-036 Reset asserted mid-END -> all outputs 0 immediately; with PWM_TIMER_POLARITY_EN, POL=1 run shows inverted duty.

Source files
------------

// File: rtl/pwm_timer_pkg.sv
// rtl/pwm_timer_pkg.sv - shared state encoding and register offsets for pwm_timer_multi
package pwm_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_END  = 2'd2
  } state_t;

  typedef logic [1:0] reg_sel_t;

  localparam reg_sel_t REG_MAX  = 2'd0;
  localparam reg_sel_t REG_DUTY = 2'd1;
  localparam reg_sel_t REG_STOP = 2'd2;
  localparam reg_sel_t REG_POL  = 2'd3;

  // A channel is busy whenever it is not parked in IDLE.
  function automatic logic is_active(input state_t st);
    return st != ST_IDLE;
  endfunction

endpackage

// File: rtl/pwm_timer_ch.sv
// rtl/pwm_timer_ch.sv - one PWM timer channel (IDLE/RUN/END); polarity register under PWM_TIMER_POLARITY_EN
module pwm_timer_ch
  import pwm_timer_pkg::*;
#(
  parameter int CW      = 16,
  parameter int END_LEN = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [1:0]    reg_sel,
  input  logic [CW-1:0] wdata,
  input  logic          start,
  input  logic          abort,
  output logic          pwm,
  output logic          timer_end,
  output logic          busy
);

  localparam logic [7:0] END_LAST = 8'(END_LEN - 1);

  state_t        state;
  logic [CW-1:0] max_q;
  logic [CW-1:0] duty_q;
  logic [CW-1:0] stop_q;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cyc;
  logic [7:0]    end_cnt;
  logic          wr_ok;
  logic          pol;

  // Register writes only land while the channel is idle.
  assign wr_ok = we && (state == ST_IDLE);
  assign busy  = is_active(state);

`ifdef PWM_TIMER_POLARITY_EN
  // Polarity bit, inverts the RUN-time compare only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pol <= 1'b0;
    end else if (wr_ok && (reg_sel == REG_POL)) begin
      pol <= wdata[0];
    end
  end
`else
  assign pol = 1'b0;
`endif

  // Config registers plus the channel FSM with registered pwm/end outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      max_q     <= '0;
      duty_q    <= '0;
      stop_q    <= '0;
      cnt       <= '0;
      cyc       <= '0;
      end_cnt   <= '0;
      pwm       <= 1'b0;
      timer_end <= 1'b0;
    end else begin
      if (wr_ok) begin
        case (reg_sel)
          REG_MAX:  max_q  <= wdata;
          REG_DUTY: duty_q <= wdata;
          REG_STOP: stop_q <= wdata;
          default:  ;
        endcase
      end

      case (state)
        ST_IDLE: begin
          pwm       <= 1'b0;
          timer_end <= 1'b0;
          if (start) begin
            state <= ST_RUN;
            cnt   <= '0;
            cyc   <= '0;
          end
        end

        ST_RUN: begin
          if (abort) begin
            state     <= ST_IDLE;
            pwm       <= 1'b0;
            timer_end <= 1'b0;
          end else if ((cyc == stop_q) || (max_q == '0)) begin
            // The last period's final level was shown during this clock,
            // so the run closes here with the output forced low.
            state     <= ST_END;
            pwm       <= 1'b0;
            timer_end <= 1'b1;
            end_cnt   <= '0;
          end else begin
            pwm <= ((cnt >= duty_q) && (cnt < max_q)) ^ pol;
            if (cnt == (max_q - CW'(1))) begin
              cnt <= '0;
              cyc <= cyc + CW'(1);
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end

        ST_END: begin
          pwm <= 1'b0;
          if (abort) begin
            state     <= ST_IDLE;
            timer_end <= 1'b0;
          end else if (end_cnt == END_LAST) begin
            state     <= ST_IDLE;
            timer_end <= 1'b0;
          end else begin
            end_cnt <= end_cnt + 8'd1;
          end
        end

        default: begin
          state     <= ST_IDLE;
          pwm       <= 1'b0;
          timer_end <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/pwm_timer_multi.sv
// rtl/pwm_timer_multi.sv - CH independent PWM timers with address decode; PWM_TIMER_POLARITY_EN enables per-channel polarity
module pwm_timer_multi
  import pwm_timer_pkg::*;
#(
  parameter int CH      = 4,
  parameter int CW      = 16,
  parameter int END_LEN = 10
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_we,
  input  logic [$clog2(CH)+1:0]  i_addr,
  input  logic [CW-1:0]          i_wdata,
  input  logic [CH-1:0]          i_start,
  input  logic [CH-1:0]          i_abort,
  output logic [CH-1:0]          o_pwm,
  output logic [CH-1:0]          o_timer_end,
  output logic [CH-1:0]          o_busy
);

  localparam int AW = $clog2(CH) + 2;

  // Channel field sits above the 2-bit register select; indices >= CH match nothing.
  logic [AW-1:0] ch_idx;
  assign ch_idx = i_addr >> 2;

  for (genvar c = 0; c < CH; c++) begin : g_ch
    logic ch_we;
    assign ch_we = i_we && (ch_idx == AW'(c));

    pwm_timer_ch #(
      .CW      (CW),
      .END_LEN (END_LEN)
    ) u_ch (
      .clk       (i_clk),
      .rst_n     (i_rst_n),
      .we        (ch_we),
      .reg_sel   (i_addr[1:0]),
      .wdata     (i_wdata),
      .start     (i_start[c]),
      .abort     (i_abort[c]),
      .pwm       (o_pwm[c]),
      .timer_end (o_timer_end[c]),
      .busy      (o_busy[c])
    );
  end

endmodule

// File: tb/tb_pwm_timer_multi.sv
// tb/tb_pwm_timer_multi.sv - directed self-checking bench for pwm_timer_multi
module tb_pwm_timer_multi;

  localparam int CH      = 4;
  localparam int CW      = 16;
  localparam int END_LEN = 10;
  localparam int AW      = 4;

  localparam logic [1:0] R_MAX  = 2'd0;
  localparam logic [1:0] R_DUTY = 2'd1;
  localparam logic [1:0] R_STOP = 2'd2;
  localparam logic [1:0] R_POL  = 2'd3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          we;
  logic [AW-1:0] addr;
  logic [CW-1:0] wdata;
  logic [CH-1:0] start;
  logic [CH-1:0] abort;
  logic [CH-1:0] pwm;
  logic [CH-1:0] tend;
  logic [CH-1:0] busy;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  always #5 clk = ~clk;

  pwm_timer_multi #(
    .CH      (CH),
    .CW      (CW),
    .END_LEN (END_LEN)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_we        (we),
    .i_addr      (addr),
    .i_wdata     (wdata),
    .i_start     (start),
    .i_abort     (abort),
    .o_pwm       (pwm),
    .o_timer_end (tend),
    .o_busy      (busy)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int ch, input logic [1:0] r, input logic [CW-1:0] d);
    logic [1:0] c2;
    c2    = 2'(ch);
    we    = 1'b1;
    addr  = {c2, r};
    wdata = d;
    tick();
    we    = 1'b0;
  endtask

  task automatic wait_idle(input int ch);
    int n;
    n = 0;
    while (busy[ch] && n < 200) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; we = 1'b0; addr = '0; wdata = '0; start = '0; abort = '0;
    repeat (3) tick();
    chk_cnt++; if (pwm !== 4'b0000) $display("FAIL reset_pwm: got %b want 0000", pwm); else pass_cnt++;
    chk_cnt++; if (tend !== 4'b0000) $display("FAIL reset_end: got %b want 0000", tend); else pass_cnt++;
    chk_cnt++; if (busy !== 4'b0000) $display("FAIL reset_busy: got %b want 0000", busy); else pass_cnt++;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic;
    logic e;
    wr(0, R_MAX, 16'd10);
    wr(0, R_DUTY, 16'd4);
    wr(0, R_STOP, 16'd3);
    start[0] = 1'b1; tick(); start[0] = 1'b0;
    chk_cnt++; if (busy[0] !== 1'b1) $display("FAIL basic_busy: got %b want 1", busy[0]); else pass_cnt++;
    chk_cnt++; if (pwm[0] !== 1'b0) $display("FAIL basic_first: got %b want 0", pwm[0]); else pass_cnt++;
    for (int i = 0; i < 30; i++) begin
      tick();
      e = ((i % 10) >= 4);
      chk_cnt++; if (pwm[0] !== e) $display("FAIL basic_pwm[%0d]: got %b want %b", i, pwm[0], e); else pass_cnt++;
    end
    tick();
    chk_cnt++; if (pwm[0] !== 1'b0) $display("FAIL basic_end_pwm: got %b want 0", pwm[0]); else pass_cnt++;
    for (int j = 0; j < END_LEN; j++) begin
      chk_cnt++; if (tend[0] !== 1'b1) $display("FAIL basic_end_hi[%0d]: got %b want 1", j, tend[0]); else pass_cnt++;
      tick();
    end
    chk_cnt++; if (tend[0] !== 1'b0) $display("FAIL basic_end_lo: got %b want 0", tend[0]); else pass_cnt++;
    chk_cnt++; if (busy[0] !== 1'b0) $display("FAIL basic_idle: got %b want 0", busy[0]); else pass_cnt++;
  endtask

  task automatic test_duty_extremes;
    wr(1, R_MAX, 16'd5);
    wr(1, R_DUTY, 16'd0);
    wr(1, R_STOP, 16'd2);
    wr(2, R_MAX, 16'd5);
    wr(2, R_DUTY, 16'd8);
    wr(2, R_STOP, 16'd2);
    start = 4'b0110; tick(); start = '0;
    chk_cnt++; if (pwm[2:1] !== 2'b00) $display("FAIL ext_first: got %b want 00", pwm[2:1]); else pass_cnt++;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk_cnt++; if (pwm[1] !== 1'b1) $display("FAIL ext_duty0[%0d]: got %b want 1", i, pwm[1]); else pass_cnt++;
      chk_cnt++; if (pwm[2] !== 1'b0) $display("FAIL ext_dutymax[%0d]: got %b want 0", i, pwm[2]); else pass_cnt++;
    end
    tick();
    chk_cnt++; if (pwm[1] !== 1'b0) $display("FAIL ext_end_pwm: got %b want 0", pwm[1]); else pass_cnt++;
    chk_cnt++; if (tend[2:1] !== 2'b11) $display("FAIL ext_end: got %b want 11", tend[2:1]); else pass_cnt++;
    wait_idle(1);
    wait_idle(2);
    chk_cnt++; if (busy[2:1] !== 2'b00) $display("FAIL ext_idle: got %b want 00", busy[2:1]); else pass_cnt++;
  endtask

  task automatic test_write_during_run;
    logic e;
    start[0] = 1'b1; tick(); start[0] = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (i == 0) begin
        we = 1'b1; addr = {2'd0, R_MAX}; wdata = 16'd20;
      end
      tick();
      we = 1'b0;
      e = ((i % 10) >= 4);
      chk_cnt++; if (pwm[0] !== e) $display("FAIL wrun_pwm[%0d]: got %b want %b", i, pwm[0], e); else pass_cnt++;
    end
    wait_idle(0);
    chk_cnt++; if (busy[0] !== 1'b0) $display("FAIL wrun_idle: got %b want 0", busy[0]); else pass_cnt++;
    start[0] = 1'b1; tick(); start[0] = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      e = ((i % 10) >= 4);
      chk_cnt++; if (pwm[0] !== e) $display("FAIL wrun_next[%0d]: got %b want %b", i, pwm[0], e); else pass_cnt++;
    end
    wait_idle(0);
    chk_cnt++; if (busy[0] !== 1'b0) $display("FAIL wrun_idle2: got %b want 0", busy[0]); else pass_cnt++;
  endtask

  task automatic test_abort;
    logic seen;
    start[0] = 1'b1; tick(); start[0] = 1'b0;
    repeat (25) tick();
    chk_cnt++; if (pwm[0] !== 1'b1) $display("FAIL abort_pre: got %b want 1", pwm[0]); else pass_cnt++;
    abort[0] = 1'b1; tick(); abort[0] = 1'b0;
    chk_cnt++; if (pwm[0] !== 1'b0) $display("FAIL abort_pwm: got %b want 0", pwm[0]); else pass_cnt++;
    chk_cnt++; if (busy[0] !== 1'b0) $display("FAIL abort_busy: got %b want 0", busy[0]); else pass_cnt++;
    seen = tend[0];
    for (int i = 0; i < 15; i++) begin
      tick();
      seen = seen | tend[0];
    end
    chk_cnt++; if (seen !== 1'b0) $display("FAIL abort_noend: got %b want 0", seen); else pass_cnt++;
  endtask

  task automatic test_zero_cases;
    wr(3, R_MAX, 16'd5);
    wr(3, R_DUTY, 16'd0);
    wr(3, R_STOP, 16'd0);
    start[3] = 1'b1; we = 1'b1; addr = {2'd3, R_STOP}; wdata = 16'd1;
    tick();
    start[3] = 1'b0; we = 1'b0;
    tick();
    chk_cnt++; if (pwm[3] !== 1'b1) $display("FAIL same_cycle_write: got %b want 1", pwm[3]); else pass_cnt++;
    wait_idle(3);
    chk_cnt++; if (busy[3] !== 1'b0) $display("FAIL zero_idle1: got %b want 0", busy[3]); else pass_cnt++;

    wr(3, R_STOP, 16'd0);
    start[3] = 1'b1; tick(); start[3] = 1'b0;
    chk_cnt++; if (busy[3] !== 1'b1) $display("FAIL stop0_busy: got %b want 1", busy[3]); else pass_cnt++;
    tick();
    chk_cnt++; if (pwm[3] !== 1'b0) $display("FAIL stop0_pwm: got %b want 0", pwm[3]); else pass_cnt++;
    chk_cnt++; if (tend[3] !== 1'b1) $display("FAIL stop0_end: got %b want 1", tend[3]); else pass_cnt++;
    wait_idle(3);

    wr(3, R_STOP, 16'd1);
    wr(3, R_MAX, 16'd0);
    start[3] = 1'b1; tick(); start[3] = 1'b0;
    tick();
    chk_cnt++; if (pwm[3] !== 1'b0) $display("FAIL max0_pwm: got %b want 0", pwm[3]); else pass_cnt++;
    chk_cnt++; if (tend[3] !== 1'b1) $display("FAIL max0_end: got %b want 1", tend[3]); else pass_cnt++;
    wait_idle(3);
    chk_cnt++; if (busy[3] !== 1'b0) $display("FAIL zero_idle2: got %b want 0", busy[3]); else pass_cnt++;
  endtask

  task automatic test_reset_mid_end;
    int n;
    start[0] = 1'b1; tick(); start[0] = 1'b0;
    n = 0;
    while (!tend[0] && n < 100) begin
      tick();
      n++;
    end
    chk_cnt++; if (tend[0] !== 1'b1) $display("FAIL rst_end_reached: got %b want 1", tend[0]); else pass_cnt++;
    tick(); tick();
    #2 rst_n = 1'b0;
    #1;
    chk_cnt++; if (tend !== 4'b0000) $display("FAIL rst_async_end: got %b want 0000", tend); else pass_cnt++;
    chk_cnt++; if (busy !== 4'b0000) $display("FAIL rst_async_busy: got %b want 0000", busy); else pass_cnt++;
    chk_cnt++; if (pwm !== 4'b0000) $display("FAIL rst_async_pwm: got %b want 0000", pwm); else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

`ifdef PWM_TIMER_POLARITY_EN
  task automatic test_polarity;
    logic e;
    wr(0, R_MAX, 16'd10);
    wr(0, R_DUTY, 16'd4);
    wr(0, R_STOP, 16'd1);
    wr(0, R_POL, 16'd1);
    start[0] = 1'b1; tick(); start[0] = 1'b0;
    chk_cnt++; if (pwm[0] !== 1'b0) $display("FAIL pol_first: got %b want 0", pwm[0]); else pass_cnt++;
    for (int i = 0; i < 10; i++) begin
      tick();
      e = (i < 4);
      chk_cnt++; if (pwm[0] !== e) $display("FAIL pol_pwm[%0d]: got %b want %b", i, pwm[0], e); else pass_cnt++;
    end
    tick();
    chk_cnt++; if (pwm[0] !== 1'b0) $display("FAIL pol_end_pwm: got %b want 0", pwm[0]); else pass_cnt++;
    wait_idle(0);
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_duty_extremes();
    test_write_during_run();
    test_abort();
    test_zero_cases();
    test_reset_mid_end();
`ifdef PWM_TIMER_POLARITY_EN
    test_polarity();
`endif
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
